// File: rtl/pe_seq_pkg.sv
// Shared definitions for the PE column sequencer.
//   seq_state_e : pass sequencing states
//   SLOT_W      : width of the slot field ({stage, clause_index})
//   OFF_*       : instr_data field offsets above the literal address field
package pe_seq_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    localparam int SLOT_W        = 3;
    localparam int OFF_SLOT      = 0;
    localparam int OFF_INV       = 3;
    localparam int OFF_FIRST     = 4;
    localparam int OFF_LAST      = 5;
    localparam int OFF_EOP       = 6;
    localparam int INSTR_EXTRA_W = 7;
endpackage

// File: rtl/pe_slot_tracker.sv
// Per-slot open/closed tracking and sticky protocol-error flag.
//   clk, rst_n : clock, async active-low reset
//   clr        : start of a new pass (clears open bits and error)
//   acc        : instruction accepted this cycle
//   slot       : slot of the accepted instruction
//   first/last : clause opens / closes at this slot
//   eop        : end of pass; every slot must be closed after this update
//   err_proto  : sticky protocol error
module pe_slot_tracker
    import pe_seq_pkg::*;
#(
    parameter int N_SLOTS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              acc,
    input  logic [SLOT_W-1:0] slot,
    input  logic              first,
    input  logic              last,
    input  logic              eop,
    output logic              err_proto
);
    logic [N_SLOTS-1:0] open_q;
    logic [N_SLOTS-1:0] open_nxt;
    logic [N_SLOTS-1:0] mask;
    logic               is_open;
    logic               bad;

    always_comb begin
        mask     = N_SLOTS'(1) << slot;
        is_open  = |(open_q & mask);
        open_nxt = open_q;
        if (first && !last)
            open_nxt = open_q | mask;
        else if (last)
            open_nxt = open_q & ~mask;
        // first must target a closed slot and a continuation an open one,
        // so first == is_open is exactly the illegal case for either.
        bad = (first == is_open) || (eop && (|open_nxt));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q    <= '0;
            err_proto <= 1'b0;
        end else if (clr) begin
            open_q    <= '0;
            err_proto <= 1'b0;
        end else if (acc) begin
            open_q <= open_nxt;
            if (bad)
                err_proto <= 1'b1;
        end
    end
endmodule

// File: rtl/pe_col_sequencer.sv
// PE column instruction sequencer.
// Accepts packed instructions during a pass, issues the literal-memory read
// in the accept cycle, drives the PE column controls one cycle later (when the
// literal arrives) and flags completed clauses one cycle after that.
//   start            : pass-start pulse (honoured only in IDLE)
//   instr_valid/ready/data : instruction handshake
//   lit_rd_en/addr   : literal-memory read (combinational from the handshake)
//   pe_ena, code_pe_stage, clause_index, inv_en, next_clause_flag : PE controls
//   result_valid/slot: clause result final
//   done             : pass complete pulse
//   err_proto        : sticky protocol error
//   lit_count        : saturating count of accepted instructions this pass
module pe_col_sequencer
    import pe_seq_pkg::*;
#(
    parameter int N_ELEMENT  = 4,
    parameter int LIT_ADDR_W = 7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic [LIT_ADDR_W+6:0]         instr_data,
    output logic                          lit_rd_en,
    output logic [LIT_ADDR_W-1:0]         lit_rd_addr,
    output logic                          pe_ena,
    output logic [1:0]                    code_pe_stage,
    output logic                          clause_index,
    output logic                          inv_en,
    output logic [2*N_ELEMENT-1:0]        next_clause_flag,
    output logic                          result_valid,
    output logic [SLOT_W-1:0]             result_slot,
    output logic                          done,
    output logic                          err_proto,
    output logic [15:0]                   lit_count
);
    localparam int N_SLOTS = 2 * N_ELEMENT;

    seq_state_e        state;
    logic              drain_last;
    logic              acc;
    logic              clr;
    logic [SLOT_W-1:0] slot;
    logic              f_inv, f_first, f_last, f_eop;
    logic              last_d1;
    logic [SLOT_W-1:0] slot_d1;

    assign slot    = instr_data[LIT_ADDR_W+OFF_SLOT +: SLOT_W];
    assign f_inv   = instr_data[LIT_ADDR_W+OFF_INV];
    assign f_first = instr_data[LIT_ADDR_W+OFF_FIRST];
    assign f_last  = instr_data[LIT_ADDR_W+OFF_LAST];
    assign f_eop   = instr_data[LIT_ADDR_W+OFF_EOP];

    assign instr_ready = (state == ST_RUN);
    assign acc         = instr_valid & instr_ready;
    assign clr         = start && (state == ST_IDLE);
    assign lit_rd_en   = acc;
    assign lit_rd_addr = instr_data[LIT_ADDR_W-1:0];

    // DRAIN covers the two cycles in which the eop instruction's controls and
    // result leave the pipeline; done lands on the second of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            drain_last <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= (state == ST_DRAIN) && !drain_last;
            case (state)
                ST_IDLE:  if (start) state <= ST_RUN;
                ST_RUN:   if (acc && f_eop) state <= ST_DRAIN;
                ST_DRAIN: begin
                    drain_last <= !drain_last;
                    if (drain_last) state <= ST_IDLE;
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Literal read at T, PE controls at T+1, clause result at T+2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_ena           <= 1'b0;
            code_pe_stage    <= '0;
            clause_index     <= 1'b0;
            inv_en           <= 1'b0;
            next_clause_flag <= '0;
            last_d1          <= 1'b0;
            slot_d1          <= '0;
            result_valid     <= 1'b0;
            result_slot      <= '0;
        end else begin
            pe_ena           <= acc;
            next_clause_flag <= (acc && f_first) ? (N_SLOTS'(1) << slot) : '0;
            last_d1          <= acc && f_last;
            result_valid     <= last_d1;
            if (acc) begin
                code_pe_stage <= slot[2:1];
                clause_index  <= slot[0];
                inv_en        <= f_inv;
                slot_d1       <= slot;
            end
            if (last_d1)
                result_slot <= slot_d1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lit_count <= '0;
        else if (clr)
            lit_count <= '0;
        else if (acc && lit_count != 16'hFFFF)
            lit_count <= lit_count + 16'd1;
    end

    pe_slot_tracker #(.N_SLOTS(N_SLOTS)) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .acc       (acc),
        .slot      (slot),
        .first     (f_first),
        .last      (f_last),
        .eop       (f_eop),
        .err_proto (err_proto)
    );
endmodule
